// File: rtl/prog_loader.sv
// Serial program loader and writable program memory for the 4-bit CPU.
// Receives a framed image over UART (8N1, LSB first): header byte HDR,
// DEPTH data bytes, then an 8-bit wrap-around checksum of the data bytes.
// A verified image is copied from a shadow buffer into program memory in
// a single cycle, and the CPU is then released from reset.
//
// Ports:
//   CLK        system clock
//   RST        asynchronous active-high reset
//   rx         UART serial input (idle high, asynchronous to CLK)
//   addr       program address from the CPU PC
//   prog_data  program word at addr (combinational read)
//   cpu_rst    reset request to the CPU (OR externally with RST)
//   loading    high while a frame is in progress
//   load_done  one-cycle pulse on the cycle a verified image is committed
//   csum_err   sticky: last frame failed its checksum
//   frame_err  sticky: last frame was aborted by a bad stop bit
module prog_loader #(
  parameter int unsigned CLK_DIV = 434,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned PROG_W  = 8,
  parameter logic [7:0]  HDR     = 8'hA5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              rx,
  input  logic [ADDR_W-1:0] addr,
  output logic [PROG_W-1:0] prog_data,
  output logic              cpu_rst,
  output logic              loading,
  output logic              load_done,
  output logic              csum_err,
  output logic              frame_err
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [ADDR_W:0]   IDX_LAST = (ADDR_W + 1)'(DEPTH - 1);

  // ---------------------------------------------------------------------
  // Input synchronizer and falling-edge detect
  // ---------------------------------------------------------------------
  logic [1:0] sync;
  logic       rxs;
  logic       rxs_d;
  logic       fall;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync  <= 2'b11;
      rxs_d <= 1'b1;
    end else begin
      sync  <= {sync[0], rx};
      rxs_d <= sync[1];
    end
  end

  assign rxs  = sync[1];
  assign fall = rxs_d & ~rxs;

  // ---------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t        r_state, r_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bitcnt, bitcnt_next;
  logic [7:0]       shreg, shreg_next;
  logic             bv_next, fe_next;
  logic             byte_valid;
  logic             rx_ferr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= R_IDLE;
      cnt        <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      rx_ferr    <= 1'b0;
    end else begin
      r_state    <= r_next;
      cnt        <= cnt_next;
      bitcnt     <= bitcnt_next;
      shreg      <= shreg_next;
      byte_valid <= bv_next;
      rx_ferr    <= fe_next;
    end
  end

  // byte_valid/rx_ferr are registered, so they are seen while the receiver
  // is already back in R_IDLE and able to catch the next start edge.
  always_comb begin
    r_next      = r_state;
    cnt_next    = cnt + 1'b1;
    bitcnt_next = bitcnt;
    shreg_next  = shreg;
    bv_next     = 1'b0;
    fe_next     = 1'b0;
    case (r_state)
      R_IDLE: begin
        cnt_next    = '0;
        bitcnt_next = '0;
        if (fall) r_next = R_START;
      end
      R_START: begin
        if (cnt == CNT_HALF) begin
          cnt_next = '0;
          r_next   = rxs ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_next    = '0;
          shreg_next  = {rxs, shreg[7:1]};
          bitcnt_next = bitcnt + 1'b1;
          if (bitcnt == 3'd7) r_next = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_next = '0;
          r_next   = R_IDLE;
          if (rxs) bv_next = 1'b1;
          else     fe_next = 1'b1;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Loader
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {L_IDLE, L_DATA, L_CSUM} ld_state_t;

  ld_state_t     l_state, l_next;
  logic [ADDR_W:0] idx, idx_next;
  logic [7:0]    sum, sum_next;
  logic          shadow_we;
  logic          commit;
  logic          arm;
  logic          clr_flags;
  logic          set_cerr;
  logic          set_ferr;

  logic [PROG_W-1:0] shadow [DEPTH];
  logic [PROG_W-1:0] mem    [DEPTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      l_state   <= L_IDLE;
      idx       <= '0;
      sum       <= '0;
      cpu_rst   <= 1'b1;
      csum_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      l_state <= l_next;
      idx     <= idx_next;
      sum     <= sum_next;
      if (arm)         cpu_rst <= 1'b1;
      else if (commit) cpu_rst <= 1'b0;
      if (clr_flags)     csum_err <= 1'b0;
      else if (set_cerr) csum_err <= 1'b1;
      if (clr_flags)     frame_err <= 1'b0;
      else if (set_ferr) frame_err <= 1'b1;
    end
  end

  always_comb begin
    l_next    = l_state;
    idx_next  = idx;
    sum_next  = sum;
    shadow_we = 1'b0;
    commit    = 1'b0;
    arm       = 1'b0;
    clr_flags = 1'b0;
    set_cerr  = 1'b0;
    set_ferr  = 1'b0;
    if (rx_ferr) begin
      set_ferr = 1'b1;
      l_next   = L_IDLE;
    end else if (byte_valid) begin
      case (l_state)
        L_IDLE: begin
          if (shreg == HDR) begin
            l_next    = L_DATA;
            idx_next  = '0;
            sum_next  = '0;
            arm       = 1'b1;
            clr_flags = 1'b1;
          end
        end
        L_DATA: begin
          shadow_we = 1'b1;
          sum_next  = sum + shreg;
          idx_next  = idx + 1'b1;
          if (idx == IDX_LAST) l_next = L_CSUM;
        end
        L_CSUM: begin
          l_next = L_IDLE;
          if (shreg == sum) commit   = 1'b1;
          else              set_cerr = 1'b1;
        end
        default: l_next = L_IDLE;
      endcase
    end
  end

  assign loading   = (l_state != L_IDLE);
  assign load_done = commit;

  always_ff @(posedge CLK) begin
    if (shadow_we) shadow[idx[ADDR_W-1:0]] <= PROG_W'(shreg);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= shadow[i];
    end
  end

  assign prog_data = mem[addr];

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with CLK_DIV=4: reset state, good load,
// checksum failure, frame error, glitch/stray bytes, async reset mid-frame.
module tb_prog_loader;

  localparam int DIV = 4;

  logic       CLK;
  logic       RST;
  logic       rx;
  logic [3:0] addr;
  logic [7:0] prog_data;
  logic       cpu_rst;
  logic       loading;
  logic       load_done;
  logic       csum_err;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  prog_loader #(.CLK_DIV(DIV)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .rx        (rx),
    .addr      (addr),
    .prog_data (prog_data),
    .cpu_rst   (cpu_rst),
    .loading   (loading),
    .load_done (load_done),
    .csum_err  (csum_err),
    .frame_err (frame_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (load_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    idle(DIV);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
    rx = 1'b1;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    chk(tag, prog_data, exp);
  endtask

  initial begin
    rx   = 1'b1;
    addr = '0;
    RST  = 1'b1;
    #12 RST = 1'b0;
    idle(3);

    // 1. reset state
    for (int a = 0; a < 16; a++) read_chk("rst_mem", 4'(a), 8'h00);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_loading", loading, 0);
    chk("rst_csum_err", csum_err, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_done", done_cnt, 0);

    // 2. good load 00..0F, checksum 0x78
    send_byte(8'hA5, 1'b1);
    idle(3);
    chk("t2_loading", loading, 1);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    chk("t2_loading_mid", loading, 1);
    chk("t2_mem_old", prog_data, 8'h00);
    send_byte(8'h78, 1'b1);
    idle(4);
    chk("t2_done", done_cnt, 1);
    chk("t2_cpu_rst", cpu_rst, 0);
    chk("t2_loading_end", loading, 0);
    chk("t2_csum_err", csum_err, 0);
    read_chk("t2_mem5", 4'd5, 8'h05);
    read_chk("t2_mem15", 4'd15, 8'h0F);
    read_chk("t2_mem0", 4'd0, 8'h00);

    // 3. bad checksum: 16 x B1 sums to 0x10, send 0x11
    send_byte(8'hA5, 1'b1);
    idle(3);
    chk("t3_cpu_rst_arm", cpu_rst, 1);
    chk("t3_loading", loading, 1);
    for (int i = 0; i < 16; i++) send_byte(8'hB1, 1'b1);
    send_byte(8'h11, 1'b1);
    idle(4);
    chk("t3_csum_err", csum_err, 1);
    chk("t3_cpu_rst", cpu_rst, 1);
    chk("t3_loading", loading, 0);
    chk("t3_done", done_cnt, 1);
    read_chk("t3_mem5", 4'd5, 8'h05);

    // 4. frame error on 4th data byte, then good frame i*0x11 (sum 0xF8)
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    idle(3);
    chk("t4_csum_clr", csum_err, 0);
    chk("t4_loading_mid", loading, 1);
    send_byte(8'h04, 1'b0);
    idle(4);
    chk("t4_frame_err", frame_err, 1);
    chk("t4_loading", loading, 0);
    chk("t4_cpu_rst", cpu_rst, 1);
    read_chk("t4_mem5", 4'd5, 8'h05);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'(i * 17), 1'b1);
    send_byte(8'hF8, 1'b1);
    idle(4);
    chk("t4_frame_clr", frame_err, 0);
    chk("t4_cpu_rst_rel", cpu_rst, 0);
    chk("t4_done", done_cnt, 2);
    read_chk("t4_mem3", 4'd3, 8'h33);
    read_chk("t4_mem15", 4'd15, 8'hFF);

    // 5. one-cycle glitch and stray bytes in idle
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(12);
    chk("t5_glitch_loading", loading, 0);
    chk("t5_glitch_ferr", frame_err, 0);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h5A, 1'b1);
    idle(4);
    chk("t5_loading", loading, 0);
    chk("t5_cpu_rst", cpu_rst, 0);
    chk("t5_frame_err", frame_err, 0);
    chk("t5_csum_err", csum_err, 0);
    chk("t5_done", done_cnt, 2);
    read_chk("t5_mem3", 4'd3, 8'h33);

    // 6. async reset in the middle of the data bytes
    send_byte(8'hA5, 1'b1);
    idle(3);
    chk("t6_cpu_rst_arm", cpu_rst, 1);
    for (int i = 0; i < 5; i++) send_byte(8'h55, 1'b1);
    rx = 1'b0;
    idle(6);
    #3 RST = 1'b1;
    #1;
    chk("t6_rst_cpu_rst", cpu_rst, 1);
    chk("t6_rst_loading", loading, 0);
    chk("t6_rst_load_done", load_done, 0);
    chk("t6_rst_csum", csum_err, 0);
    chk("t6_rst_frame", frame_err, 0);
    chk("t6_rst_mem", prog_data, 8'h00);
    rx = 1'b1;
    idle(2);
    RST = 1'b0;
    idle(4);
    chk("t6_loading_after", loading, 0);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i), 1'b1);
    send_byte(8'h78, 1'b1);
    idle(4);
    chk("t6_done", done_cnt, 3);
    chk("t6_cpu_rst", cpu_rst, 0);
    read_chk("t6_mem2", 4'd2, 8'h82);
    read_chk("t6_mem15", 4'd15, 8'h8F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Serial program loader and writable program memory for the 4-bit CPU.
- Replaces the fixed program ROM: the CPU PC drives `addr` and receives `prog_data` combinationally.
- Receives a framed program image over a UART line (8N1, LSB first), verifies it with a checksum, and stores it.
- Holds the CPU in reset until a verified image is present.

Parameters:
- CLK_DIV, 434: CLK cycles per UART bit (at least 4; set to 4 in simulation).
- DEPTH, 16: program words; must equal 2**ADDR_W.
- ADDR_W, 4: address width; matches DATA_WIDTH.
- PROG_W, 8: program word width; opcode is [7:4], immediate is [3:0].
- HDR, 8'hA5: header byte that opens a load frame.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- rx  in  1  UART serial input; idles high; asynchronous to CLK.
- addr  in  ADDR_W  program address from the CPU PC.
- prog_data  out  PROG_W  program word at `addr`.
- cpu_rst  out  1  reset request to the CPU; OR this externally with RST.
- loading  out  1  high while a frame is in progress.
- load_done  out  1  one-cycle pulse when a verified image is committed.
- csum_err  out  1  sticky flag: the last frame failed its checksum.
- frame_err  out  1  sticky flag: the last frame was aborted by a bad stop bit.

Behaviour:
- Reset (asynchronous, RST=1):
  - All memory words = 0.
  - cpu_rst=1, loading=0, load_done=0, csum_err=0, frame_err=0.
  - Synchronizer flops = 1; both FSMs return to their idle states.
  - Reset mid-frame discards the partial frame.
- Input synchronization: `rx` passes through a 2-flop synchronizer. All logic uses the synchronized value `rxs`.
- Receiver FSM (states R_IDLE, R_START, R_DATA, R_STOP):
  - R_IDLE: falling edge of `rxs` -> R_START; bit counter = 0.
  - R_START: after CLK_DIV/2 cycles, sample the line. Low -> R_DATA. High -> R_IDLE (glitch rejected; no error).
  - R_DATA: sample every CLK_DIV cycles and shift LSB first. After 8 bits -> R_STOP.
  - R_STOP: sample after CLK_DIV cycles.
    - High: `byte_valid` pulses for 1 cycle carrying the received byte; -> R_IDLE.
    - Low: `frame_err` pulses internally; no `byte_valid`; -> R_IDLE.
- Loader FSM (states L_IDLE, L_DATA, L_CSUM):
  - L_IDLE: on `byte_valid` with byte == HDR:
    - -> L_DATA; word index = 0; sum = 0; loading=1.
    - Clear the csum_err and frame_err flags.
    - Any other byte is ignored.
  - L_DATA: each `byte_valid` writes a shadow buffer entry `shadow[idx]` = byte and updates sum = (sum + byte) mod 256.
    - idx increments on each byte.
    - After the byte at idx == DEPTH-1 -> L_CSUM.
  - L_CSUM: on `byte_valid`, compare the byte with sum.
    - Equal: in one cycle copy shadow into memory; load_done pulses 1 cycle; cpu_rst=0 from the next cycle; loading=0; -> L_IDLE.
    - Not equal: csum_err=1; memory unchanged; cpu_rst unchanged; loading=0; -> L_IDLE.
  - A receiver frame error in L_DATA or L_CSUM: frame_err=1; abort to L_IDLE; loading=0; memory and cpu_rst unchanged.
  - A frame error in L_IDLE: frame_err=1 only.
- cpu_rst is asserted (=1) on the cycle `loading` rises, and stays high for the whole frame.
  - A failed or aborted frame leaves cpu_rst=1 if it was already 1.
  - A CPU that ran a previous image therefore stays halted until a good frame arrives.
- A good commit releases the CPU from PC 0, because the CPU counter was held in reset.
- `prog_data` = mem[addr], combinational, zero latency.
  - The shadow buffer is never visible on `prog_data`.
  - Mid-load reads return the old image; the CPU is held in reset anyway.
- Simultaneous events:
  - `byte_valid` and a new falling edge on the same cycle: the receiver is already back in R_IDLE and detects the edge on that cycle; no byte is lost.
  - The commit cycle and an `addr` change: `prog_data` reflects the new memory from the cycle after the commit.
- Width rules:
  - sum is 8-bit with wrap-around.
  - idx is ADDR_W+1 bits, which avoids aliasing at DEPTH.

Test Plan (all with CLK_DIV=4):
1. Reset, then hold rx=1 -> cpu_rst=1; prog_data=8'h00 for all addr; all flags=0.
2. Send A5, bytes 00..0F, then 78 (sum 0x78) -> load_done pulses once; cpu_rst=0 next cycle; addr=5 gives prog_data=8'h05 and addr=15 gives 8'h0F.
3. After scenario 2, send A5, 16 bytes of B1, then checksum 0x11 -> csum_err=1; cpu_rst=1; addr=5 still gives 8'h05.
4. Send A5 and 3 data bytes, the 4th with its stop bit = 0 -> frame_err=1; loading=0; memory unchanged. A following valid frame loads correctly and clears frame_err.
5. Low glitch on rx lasting 1 bit/4 (1 cycle) -> no byte and no error. Stray bytes 3C and 5A in L_IDLE -> ignored, no state change.
6. Assert RST asynchronously (between CLK edges) midway through the data bytes -> all outputs return to reset values immediately. A subsequent full frame loads correctly.
